// File: rtl/div_result_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) for the divider quotient.
// Define BCD_BLANK_EN to replace leading zero digits above the units digit with 4'hF.
module div_result_bcd #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy,
  output logic                  overflow
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state, w_next;
  logic [BW-1:0]   r_scr;
  logic [WIDTH-1:0] r_bin;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic [BW-1:0]   w_adj, w_scr_nxt, w_load;
  logic            w_ovf_nxt, w_last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? r_scr[4*g +: 4] + 4'd3
                                                           : r_scr[4*g +: 4];
    end
  endgenerate

  // Bit shifted out of the top digit means the value no longer fits in DIGITS digits.
  assign w_scr_nxt = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_ovf_nxt = r_ovf | w_adj[BW-1];
  assign w_last    = (r_cnt == CW'(WIDTH-1));

  always_comb begin
    w_load = w_scr_nxt;
`ifdef BCD_BLANK_EN
    begin
      logic v_lead;
      v_lead = 1'b1;
      for (int d = DIGITS-1; d >= 1; d--) begin
        if (v_lead && (w_scr_nxt[4*d +: 4] == 4'd0)) w_load[4*d +: 4] = 4'hF;
        else                                         v_lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:                w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  always_comb begin
    valid = (r_state == DONE);
    busy  = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scr    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_bin <= bin_in;
          r_scr <= '0;
          r_ovf <= 1'b0;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_scr <= w_scr_nxt;
          r_bin <= r_bin << 1;
          r_ovf <= w_ovf_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            bcd      <= w_load;
            overflow <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
